id_ex_skid_stage: RTL and testbench

Parametrised successor to the decode-stage output register: a two-entry ID/EX skid buffer that carries the decoded instruction bundle from decode to execute under a valid/ready handshake. It inserts hazard bubbles without consuming upstream, and kills branch-shadow instructions into NOPs. A halt instruction stops upstream acceptance permanently. It honours the debug unit's global step enable. It sits between the decoder/control/register-file logic and the execute stage.

---
 rtl/id_ex_skid_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_skid_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_stage.sv
// ID/EX two-entry skid buffer: decoded bundle from decode to execute with bubble/kill/halt handling.
// Optional performance counters are built only when ID_PERF_COUNTERS_EN is defined.
module id_ex_skid_stage #(
  parameter int                    DATA_WIDTH = 128,
  parameter int                    CTRL_WIDTH = 16,
  parameter logic [CTRL_WIDTH-1:0] NOP_CTRL   = 16'h0020,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_soft_reset,
  input  logic                  i_enable_pipeline,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_halt,
  input  logic                  i_bit_burbuja_hazard,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_halt_detected,
  output logic                  o_halted,
  output logic [CNT_WIDTH-1:0]  o_cnt_bubbles,
  output logic [CNT_WIDTH-1:0]  o_cnt_kills,
  output logic [CNT_WIDTH-1:0]  o_cnt_stalls
);

  localparam int DP_WIDTH = DATA_WIDTH - CTRL_WIDTH;

  logic                  r_main_valid, r_skid_valid;
  logic                  r_main_halt,  r_skid_halt;
  logic [DATA_WIDTH-1:0] r_main_data,  r_skid_data;
  logic                  r_halted;
  logic [DP_WIDTH-1:0]   r_last_dp;

  logic                  w_hazard_req, w_pop, w_accept, w_kill, w_bubble, w_write, w_stall;
  logic                  w_wr_halt;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // A flush overrides a simultaneous hazard, so the hazard only blocks upstream when unflushed.
  assign w_hazard_req = i_bit_burbuja_hazard & ~i_flush;
  assign o_ready      = ~r_skid_valid & ~r_halted & ~w_hazard_req;

  assign w_pop    = i_enable_pipeline & r_main_valid & i_ready;
  assign w_accept = i_enable_pipeline & i_valid & o_ready;
  assign w_kill   = w_accept & i_flush;
  assign w_bubble = i_enable_pipeline & w_hazard_req & ~r_skid_valid;
  assign w_write  = w_accept | w_bubble;
  assign w_stall  = i_enable_pipeline & i_valid & ~o_ready & ~r_halted;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_wr_data = i_data;
    w_wr_halt = i_halt;
    if (w_bubble) begin
      w_wr_data = {r_last_dp, NOP_CTRL};
      w_wr_halt = 1'b0;
    end else if (w_kill) begin
      w_wr_data = {i_data[DATA_WIDTH-1:CTRL_WIDTH], NOP_CTRL};
      w_wr_halt = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all entries update from pre-edge values.
  // Both entries are reset (not just their valid bits) because o_data must read 0 out of reset.
  always_ff @(negedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      r_main_valid <= 1'b0;
      r_main_halt  <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_halt  <= 1'b0;
      r_skid_data  <= '0;
      r_halted     <= 1'b0;
      r_last_dp    <= '0;
    end else begin
      if (w_pop) begin
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_halt  <= r_skid_halt;
          r_main_data  <= r_skid_data;
          r_skid_valid <= 1'b0;
        end else if (w_write) begin
          r_main_halt  <= w_wr_halt;
          r_main_data  <= w_wr_data;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_write) begin
        if (r_main_valid) begin
          r_skid_valid <= 1'b1;
          r_skid_halt  <= w_wr_halt;
          r_skid_data  <= w_wr_data;
        end else begin
          r_main_valid <= 1'b1;
          r_main_halt  <= w_wr_halt;
          r_main_data  <= w_wr_data;
        end
      end
      if (w_write) r_last_dp <= w_wr_data[DATA_WIDTH-1:CTRL_WIDTH];
      if (w_accept & ~i_flush & i_halt) r_halted <= 1'b1;
    end
  end

  assign o_valid         = r_main_valid;
  assign o_data          = r_main_data;
  assign o_halt_detected = r_main_valid & r_main_halt;
  assign o_halted        = r_halted;

`ifdef ID_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_cnt_bubbles, r_cnt_kills, r_cnt_stalls;

  always_ff @(negedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      r_cnt_bubbles <= '0;
      r_cnt_kills   <= '0;
      r_cnt_stalls  <= '0;
    end else begin
      if (w_bubble && r_cnt_bubbles != '1) r_cnt_bubbles <= r_cnt_bubbles + 1'b1;
      if (w_kill   && r_cnt_kills   != '1) r_cnt_kills   <= r_cnt_kills + 1'b1;
      if (w_stall  && r_cnt_stalls  != '1) r_cnt_stalls  <= r_cnt_stalls + 1'b1;
    end
  end

  assign o_cnt_bubbles = r_cnt_bubbles;
  assign o_cnt_kills   = r_cnt_kills;
  assign o_cnt_stalls  = r_cnt_stalls;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
  assign o_cnt_bubbles  = '0;
  assign o_cnt_kills    = '0;
  assign o_cnt_stalls   = '0;
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage: a queue model of the two entries predicts every cycle's outputs.
// Counter expectations follow ID_PERF_COUNTERS_EN (zero when the counters are not built).
module tb_id_ex_skid_stage;

  localparam int DW = 128;
  localparam int CW = 16;
  localparam int NW = 16;
  localparam logic [CW-1:0] NOP = 16'h0020;

  logic          i_clock = 1'b0;
  logic          i_soft_reset;
  logic          i_enable_pipeline;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          i_halt;
  logic          i_bit_burbuja_hazard;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_halt_detected;
  logic          o_halted;
  logic [NW-1:0] o_cnt_bubbles, o_cnt_kills, o_cnt_stalls;

  id_ex_skid_stage dut (
    .i_clock              (i_clock),
    .i_soft_reset         (i_soft_reset),
    .i_enable_pipeline    (i_enable_pipeline),
    .i_valid              (i_valid),
    .o_ready              (o_ready),
    .i_data               (i_data),
    .i_halt               (i_halt),
    .i_bit_burbuja_hazard (i_bit_burbuja_hazard),
    .i_flush              (i_flush),
    .o_valid              (o_valid),
    .i_ready              (i_ready),
    .o_data               (o_data),
    .o_halt_detected      (o_halt_detected),
    .o_halted             (o_halted),
    .o_cnt_bubbles        (o_cnt_bubbles),
    .o_cnt_kills          (o_cnt_kills),
    .o_cnt_stalls         (o_cnt_stalls)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [DW-1:0] data;
    logic          halt;
  } entry_t;

  entry_t          sb_q[$];
  logic            m_halted;
  logic [DW-CW-1:0] m_last_dp;
  logic [NW-1:0]   m_bubbles, m_kills, m_stalls;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_halted  = 1'b0;
    m_last_dp = '0;
    m_bubbles = '0;
    m_kills   = '0;
    m_stalls  = '0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_bubbles"}, DW'(o_cnt_bubbles), DW'(m_bubbles));
    check({tag, "_kills"},   DW'(o_cnt_kills),   DW'(m_kills));
    check({tag, "_stalls"},  DW'(o_cnt_stalls),  DW'(m_stalls));
  endtask

  // One clock: compare on the rising edge, advance the model, let the DUT's falling edge pass.
  task automatic cycle();
    int     sz;
    logic   hz_req, exp_ready, pop, acc, bub, stall;
    entry_t e;
    @(posedge i_clock);
    sz        = sb_q.size();
    hz_req    = i_bit_burbuja_hazard & ~i_flush;
    exp_ready = (sz < 2) && !m_halted && !hz_req;
    check("o_ready", DW'(o_ready), DW'(exp_ready));
    check("o_valid", DW'(o_valid), DW'(sz > 0));
    if (sz > 0) begin
      check("o_data", o_data, sb_q[0].data);
      check("o_halt_detected", DW'(o_halt_detected), DW'(sb_q[0].halt));
    end else begin
      check("o_halt_detected", DW'(o_halt_detected), '0);
    end
    check("o_halted", DW'(o_halted), DW'(m_halted));
    check_counters("cnt");

    pop   = i_enable_pipeline && (sz > 0) && i_ready;
    acc   = i_enable_pipeline && i_valid && exp_ready;
    bub   = i_enable_pipeline && hz_req && (sz < 2);
    stall = i_enable_pipeline && i_valid && !exp_ready && !m_halted;
    if (pop) void'(sb_q.pop_front());
    if (acc) begin
      e.data = i_flush ? {i_data[DW-1:CW], NOP} : i_data;
      e.halt = i_halt && !i_flush;
      sb_q.push_back(e);
      m_last_dp = i_data[DW-1:CW];
      if (i_halt && !i_flush) m_halted = 1'b1;
    end else if (bub) begin
      e.data = {m_last_dp, NOP};
      e.halt = 1'b0;
      sb_q.push_back(e);
    end
`ifdef ID_PERF_COUNTERS_EN
    if (bub && m_bubbles != '1)          m_bubbles++;
    if (acc && i_flush && m_kills != '1) m_kills++;
    if (stall && m_stalls != '1)         m_stalls++;
`else
    stall = stall;
`endif
    @(negedge i_clock);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_halt = 1'b0; i_bit_burbuja_hazard = 1'b0; i_flush = 1'b0;
    i_data  = '0;   i_ready = 1'b1; i_enable_pipeline = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    i_soft_reset = 1'b0;
    #12;
    check("rst_o_valid", DW'(o_valid), '0);
    check("rst_o_data", o_data, '0);
    check("rst_o_halted", DW'(o_halted), '0);
    check("rst_o_halt_detected", DW'(o_halt_detected), '0);
    check("rst_o_ready", DW'(o_ready), DW'(1));
    check_counters("rst");
    #1 i_soft_reset = 1'b1;

    // Streaming at full rate
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1; i_data = DW'(k);
      cycle();
      check("stream_o_data", o_data, DW'(k));
    end
    i_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure from empty, then release
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = DW'(16'h100 + k);
      cycle();
    end
    check("bp_o_ready", DW'(o_ready), '0);
    i_ready = 1'b1;
    for (int k = 4; k < 7; k++) begin
      i_data = DW'(16'h100 + k);
      cycle();
    end
    i_valid = 1'b0;
    repeat (3) cycle();

    // Bubble: NOP carrying the previous datapath bits, then the held bundle
    i_valid = 1'b1; i_data = {112'hBEEF_CAFE, 16'h1234};
    cycle();
    i_data = DW'(8'hAB); i_bit_burbuja_hazard = 1'b1;
    cycle();
    check("bubble_o_data", o_data, {112'hBEEF_CAFE, NOP});
    i_bit_burbuja_hazard = 1'b0;
    cycle();
    check("after_bubble_o_data", o_data, DW'(8'hAB));
    i_valid = 1'b0;
    repeat (2) cycle();

    // Flush and hazard together: upstream consumed as a killed NOP
    i_valid = 1'b1; i_flush = 1'b1; i_bit_burbuja_hazard = 1'b1;
    i_data = {112'h77, 16'hFFFF}; i_halt = 1'b1;
    cycle();
    check("kill_o_data", o_data, {112'h77, NOP});
    check("kill_not_halted", DW'(o_halted), '0);
    idle_inputs();
    repeat (2) cycle();

    // Debug step: hold with handshakes pending
    i_ready = 1'b0; i_valid = 1'b1; i_data = DW'(16'h55);
    cycle();
    i_enable_pipeline = 1'b0; i_ready = 1'b1; i_data = DW'(16'h66);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("step_hold_o_data", o_data, DW'(16'h55));
    end
    i_enable_pipeline = 1'b1;
    cycle();
    check("step_resume_o_data", o_data, DW'(16'h66));
    i_valid = 1'b0;
    repeat (2) cycle();

    // Halt, then asynchronous reset with an entry still held
    i_ready = 1'b0; i_valid = 1'b1; i_data = DW'(16'h77);
    cycle();
    i_data = DW'(16'h88); i_halt = 1'b1;
    cycle();
    i_data = DW'(16'h99); i_halt = 1'b0;
    cycle();
    i_ready = 1'b1; i_valid = 1'b0;
    cycle();
    check("halt_detected", DW'(o_halt_detected), DW'(1));
    check("halted_sticky", DW'(o_halted), DW'(1));
    check("halted_ready", DW'(o_ready), '0);
    i_ready = 1'b0;
    #2 i_soft_reset = 1'b0;
    #1;
    model_reset();
    check("arst_o_valid", DW'(o_valid), '0);
    check("arst_o_halted", DW'(o_halted), '0);
    check_counters("arst");
    i_soft_reset = 1'b1;
    idle_inputs();
    i_valid = 1'b1; i_data = DW'(16'h42);
    cycle();
    check("post_reset_o_data", o_data, DW'(16'h42));
    i_valid = 1'b0;
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
